// File: rtl/store_narrow_unit_if.sv
// Store request and data-memory bundle for store_narrow_unit.
// The requester/memory side uses master and the store unit uses slave.
interface store_narrow_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_size;
  logic        done;
  logic        misaligned;
  logic [29:0] mem_addr;
  logic        mem_re;
  logic [31:0] mem_rdata;
  logic        mem_we;
  logic [31:0] mem_wdata;

  modport slave (
    input  req_valid, req_addr, req_data, req_size, mem_rdata,
    output req_ready, done, misaligned, mem_addr, mem_re, mem_we, mem_wdata
  );

  modport master (
    output req_valid, req_addr, req_data, req_size, mem_rdata,
    input  req_ready, done, misaligned, mem_addr, mem_re, mem_we, mem_wdata
  );
endinterface

// File: rtl/store_narrow_unit.sv
// MIPS sb/sh/sw narrowing with read-modify-write to a word memory; write 1 cycle after accept (word), 3 (sub-word).
// req_ready only in IDLE, so the requester holds its request while the unit is busy.
module store_narrow_unit (
  input  logic                 clk,
  input  logic                 rst,
  store_narrow_unit_if.slave   bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] READ  = 3'd1;
  localparam logic [2:0] MERGE = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
  localparam logic [2:0] ERR   = 3'd4;

  logic [2:0]  state;
  logic [31:0] addr_q;
  logic [15:0] data_q;
  logic [1:0]  size_q;
  logic [31:0] wdata_q;
  logic [31:0] merged;

  // Big-endian lanes: byte offset 0 is the most significant byte.
  always_comb begin
    merged = bus.mem_rdata;
    if (size_q == 2'b00) begin
      case (addr_q[1:0])
        2'd0:    merged[31:24] = data_q[7:0];
        2'd1:    merged[23:16] = data_q[7:0];
        2'd2:    merged[15:8]  = data_q[7:0];
        default: merged[7:0]   = data_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      merged[15:0] = data_q;
    end else begin
      merged[31:16] = data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      size_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            addr_q <= bus.req_addr;
            data_q <= bus.req_data[15:0];
            size_q <= bus.req_size;
            if (bus.req_size == 2'b10 && bus.req_addr[1:0] == 2'b00) begin
              wdata_q <= bus.req_data;
              state   <= WRITE;
            end else if (bus.req_size == 2'b00 ||
                         (bus.req_size == 2'b01 && !bus.req_addr[0])) begin
              state <= READ;
            end else begin
              state <= ERR;
            end
          end
        end
        READ:  state <= MERGE;
        MERGE: begin
          wdata_q <= merged;
          state   <= WRITE;
        end
        WRITE:   state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.mem_re     = (state == READ);
  assign bus.mem_we     = (state == WRITE);
  assign bus.done       = (state == WRITE);
  assign bus.misaligned = (state == ERR);
  assign bus.mem_addr   = (state == IDLE) ? 30'd0 : addr_q[31:2];
  assign bus.mem_wdata  = wdata_q;

endmodule

// File: doc/store_narrow_unit.md
# store_narrow_unit

- Handles MIPS store instructions (sb, sh, sw) against a single-port, word-wide data memory that has no byte enables.
- Narrows the 32-bit register operand to a byte or halfword, the inverse of the immediate/load sign-extension path.
- For sub-word stores it merges the narrow value into the addressed word with a read-modify-write sequence.
- Sits between the MEM-stage store request and the data memory, and stalls the pipeline while busy.

## Interface

Parameters:
- none; address and data widths are fixed at 32 bits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- req_valid  input  1  store request present
- req_ready  output  1  unit idle and able to accept a request
- req_addr  input  32  byte address of the store
- req_data  input  32  register operand; only the low 8/16/32 bits are stored
- req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved
- done  output  1  one-cycle pulse in the cycle the memory write is issued
- misaligned  output  1  one-cycle pulse when a request is rejected
- mem_addr  output  30  word address, equal to req_addr[31:2]
- mem_re  output  1  memory read strobe
- mem_rdata  input  32  read data, valid the cycle after mem_re
- mem_we  output  1  memory write strobe
- mem_wdata  output  32  write data

## Operation

States: IDLE, READ, MERGE, WRITE, ERR.

- Accept: a request is accepted when req_valid && req_ready. req_ready = (state == IDLE).
- On accept, the unit latches addr, data and size.
  - Word with addr[1:0]==00 → WRITE, with mem_wdata = req_data.
  - Byte (any offset) or half with addr[0]==0 → READ.
  - Half with addr[0]==1, word with addr[1:0]!=00, or size 11 → ERR.
- READ: mem_re=1 and mem_addr = latched addr[31:2]; next state MERGE.
- MERGE: captures mem_rdata, replaces the selected lane and leaves the other lanes unchanged; next state WRITE.
- WRITE: mem_we=1 and done=1; next state IDLE.
- ERR: misaligned=1 with no memory access; next state IDLE.
- Lane mapping is big-endian.
  - Byte offset k occupies bits [31-8k : 24-8k] and takes req_data[7:0].
  - Half offset 0 occupies [31:16] and half offset 2 occupies [15:0]; both take req_data[15:0].
- Bits of req_data above the stored width are discarded, with no overflow check.
- mem_addr holds the latched word address from accept until return to IDLE, and is 0 in IDLE.
- mem_re and mem_we are never high in the same cycle.
- req_valid is ignored outside IDLE. The requester must hold the request until it sees req_ready.

## Timing

- Reset (rst high at a rising edge):
  - state goes to IDLE.
  - mem_re, mem_we, done, misaligned, mem_addr and mem_wdata all go to 0.
  - Latched registers are cleared.
  - req_ready=1 from the first cycle after the reset edge.
  - While rst is high, req_valid is ignored.
- Reset mid-operation (READ, MERGE or WRITE) aborts the store.
  - No mem_we is issued after the reset edge.
  - done does not pulse.
- Accept at edge N:
  - Word store: mem_we and done in cycle N+1; req_ready again in N+2.
  - Byte or half store: mem_re in N+1, mem_rdata captured at end of N+2, mem_we and done in N+3, req_ready in N+4.
  - Rejected request: misaligned in N+1, req_ready in N+2.
- Back-to-back requests: a new request can be accepted in the first IDLE cycle after WRITE or ERR. Throughput is 1 word store per 2 cycles and 1 sub-word store per 4 cycles.
- All outputs are functions of registered state. There is no combinational path from req_* or mem_rdata to any output.

## Test plan

- Word store:
  - Stimulus: addr=0x00000010, data=0xDEADBEEF, size=10.
  - Response: mem_we and done exactly one cycle after accept, mem_addr=0x4, mem_wdata=0xDEADBEEF, mem_re never asserted.
- Byte store at each offset:
  - Stimulus: memory word 0x11223344; data=0xFFFFFFAB at addr 0x20/0x21/0x22/0x23.
  - Response: mem_wdata = 0xAB223344 / 0x11AB3344 / 0x1122AB44 / 0x112233AB, with mem_re one cycle before the merge and the write 3 cycles after accept.
- Halfword store:
  - Stimulus: memory word 0x11223344; data=0x0000CAFE at addr 0x30 and 0x32.
  - Response: mem_wdata = 0xCAFE3344 and 0x1122CAFE respectively.
- Misaligned requests:
  - Stimulus: half at 0x31, word at 0x42, and size=11 at 0x40.
  - Response: misaligned pulses one cycle after each accept, with mem_re=mem_we=0 and done=0 throughout.
- Reset mid-operation:
  - Stimulus: start a byte store and assert rst during the MERGE cycle.
  - Response: no mem_we; all outputs 0 and req_ready=1 the cycle after reset. A subsequent word store then completes normally.
- Back-to-back traffic:
  - Stimulus: hold req_valid high with sb, sw, sh queued.
  - Response: each request is accepted only while req_ready=1, and mem_we pulses occur at accept+3, accept+1 and accept+3 relative to each request's own accept edge.
